// File: rtl/fifo_pkg.sv
// Shared types for the FIFO drain: default data width and drain state encoding.
// The drain state value doubles as the number of bytes held in the skid buffer.
package fifo_pkg;

  localparam int DATA_WIDTH_DEF = 8;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } drain_st_t;

  function automatic logic [1:0] held_cnt(input drain_st_t s);
    return s;
  endfunction

endpackage

// File: rtl/drain_skid.sv
// Two-entry skid storage (head, tail) for the FIFO drain.
// Head is the presented stream word; tail shifts into head on a pop.
module drain_skid
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_ld_head,
  input  logic                  i_ld_tail,
  input  logic                  i_shift,
  input  logic [DATA_WIDTH-1:0] i_din,
  output logic [DATA_WIDTH-1:0] o_head
);

  logic [DATA_WIDTH-1:0] r_head;
  logic [DATA_WIDTH-1:0] r_tail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_tail <= '0;
    end else begin
      if (i_shift)
        r_head <= r_tail;
      else if (i_ld_head)
        r_head <= i_din;
      if (i_ld_tail)
        r_tail <= i_din;
    end
  end

  assign o_head = r_head;

endmodule

// File: rtl/fifo_drain.sv
// Drains a 1-cycle-latency FIFO RAM into a valid/ready byte stream.
// Optional FIFO_DRAIN_COUNT_EN adds a 16-bit delivered-byte counter port.
module fifo_drain
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  stack_empty,
  input  logic [DATA_WIDTH-1:0] Data_out,
  output logic                  read_from_stack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_DRAIN_COUNT_EN
  ,
  output logic [15:0]           byte_count
`endif
);

  localparam int LW = ADDR_WIDTH + 1;

  drain_st_t     r_state;
  logic          r_valid;
  logic          r_inflight;
  logic          w_pop;
  logic          w_cap;
  logic          w_rd;
  logic [LW-1:0] w_lvl;
  logic          w_ld_head;
  logic          w_ld_tail;
  logic          w_shift;

  assign w_pop = r_valid & out_ready;
  assign w_cap = r_inflight;

  // Occupancy after this cycle's pop, counting the byte still in the RAM.
  assign w_lvl = LW'(held_cnt(r_state))
               + LW'(r_inflight)
               - LW'(w_pop);

  assign w_rd = !rst && !stack_empty && (w_lvl < LW'(2));

  assign read_from_stack = w_rd;
  assign out_valid       = r_valid;

  always_comb begin
    w_ld_head = 1'b0;
    w_ld_tail = 1'b0;
    w_shift   = 1'b0;
    unique case (1'b1)
      (r_state == TWO): w_shift = w_pop;
      (r_state == ONE): begin
        w_ld_head = w_cap & w_pop;
        w_ld_tail = w_cap & !w_pop;
      end
      default: w_ld_head = w_cap;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= EMPTY;
      r_valid    <= 1'b0;
      r_inflight <= 1'b0;
    end else begin
      r_inflight <= w_rd;
      unique case (r_state)
        EMPTY: begin
          if (w_cap) begin
            r_state <= ONE;
            r_valid <= 1'b1;
          end
        end
        ONE: begin
          if (w_cap && !w_pop) begin
            r_state <= TWO;
          end else if (!w_cap && w_pop) begin
            r_state <= EMPTY;
            r_valid <= 1'b0;
          end
        end
        TWO: begin
          if (w_pop)
            r_state <= ONE;
        end
        default: begin
          r_state <= EMPTY;
          r_valid <= 1'b0;
        end
      endcase
    end
  end

  drain_skid #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .i_ld_head (w_ld_head),
    .i_ld_tail (w_ld_tail),
    .i_shift   (w_shift),
    .i_din     (Data_out),
    .o_head    (out_data)
  );

`ifdef FIFO_DRAIN_COUNT_EN
  logic [15:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_cnt <= '0;
    else if (w_pop)
      r_cnt <= r_cnt + 16'd1;
  end

  assign byte_count = r_cnt;
`endif

endmodule

// File: doc/fifo_drain.md
FIFO_DRAIN -- requirements
Module: fifo_drain

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8: width of FIFO data and output stream.
REQ-002 SHALL have parameter ADDR_WIDTH, default 3: FIFO depth exponent (8 entries), used only for level accounting.
REQ-003 SHALL have port clk  input  1  single clock, all logic rising-edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port stack_empty  input  1  FIFO empty flag from FIFO control.
REQ-006 SHALL have port Data_out  input  DATA_WIDTH  FIFO RAM read data, valid one cycle after read_from_stack.
REQ-007 SHALL have port read_from_stack  output  1  pop request to FIFO, one pop per asserted cycle.
REQ-008 SHALL have port out_valid  output  1  stream data valid.
REQ-009 SHALL have port out_ready  input  1  downstream accepts when out_valid and out_ready are both high.
REQ-010 SHALL have port out_data  output  DATA_WIDTH  stream data, stable while out_valid and not out_ready.
REQ-011 SHALL have port byte_count  output  16  bytes delivered, present only under FIFO_DRAIN_COUNT_EN.

Function
REQ-012 SHALL keep a 2-entry skid buffer (head, tail) plus an in-flight flag for the 1-cycle RAM latency.
REQ-013 SHALL assert read_from_stack iff !stack_empty and (held + inflight - pop_this_cycle) < 2, where pop = out_valid & out_ready.
REQ-014 SHALL capture Data_out into the buffer on the cycle after read_from_stack, into head if empty or head leaving, else tail.
REQ-015 SHALL use states EMPTY (0 held), ONE (1 held), TWO (2 held); out_valid high in ONE and TWO.
REQ-016 Transitions: EMPTY->ONE on capture; ONE->TWO on capture without pop; ONE->EMPTY on pop without capture; ONE->ONE on capture with pop; TWO->ONE on pop (tail moves to head).
REQ-017 SHALL never capture in TWO; REQ-013 guarantees no in-flight data when TWO is entered without pop.
REQ-018 SHALL sustain one byte per cycle with out_ready held high and FIFO non-empty; first-byte latency 2 cycles from stack_empty falling to out_valid.
REQ-019 SHALL preserve FIFO order exactly; no byte dropped or duplicated under any out_ready pattern.
REQ-020 SHALL hold out_data and out_valid unchanged while out_valid & !out_ready.
REQ-021 SHALL ignore stack_empty toggling while a read is in flight; capture proceeds.

Reset
REQ-022 SHALL, on rst high, asynchronously force state EMPTY, inflight 0, read_from_stack 0, out_valid 0, out_data 0, byte_count 0.
REQ-023 SHALL discard buffered and in-flight bytes on reset mid-operation; first post-reset pop no earlier than the first clk edge after rst falls.

Configuration
REQ-024 With FIFO_DRAIN_COUNT_EN defined SHALL expose byte_count, incrementing by 1 per pop, wrapping 16'hFFFF->0.
REQ-025 Without FIFO_DRAIN_COUNT_EN SHALL omit the port and counter; all other behaviour identical.

Structure
REQ-026 SHALL place DATA_WIDTH default and the drain state encoding (EMPTY=2'd0, ONE=2'd1, TWO=2'd2) in shared package fifo_pkg.
REQ-027 SHALL implement the 2-entry buffer as sub-module drain_skid; pop/capture/level control stays in fifo_drain.

Verification
REQ-028 FIFO holds 8'h11,8'h22,8'h33, out_ready=1 -> out_data 11,22,33 on consecutive cycles, first valid 2 cycles after first read_from_stack... after stack_empty low.
REQ-029 FIFO holds 8 bytes, out_ready=0 -> exactly 2 pops then read_from_stack stays 0, out_data=first byte stable; raise out_ready -> all 8 delivered in order.
REQ-030 out_ready toggling 1,0,1,0 with 5 bytes A0..A4 -> sequence A0..A4 with no loss or repeat, read_from_stack never asserted with stack_empty=1.
REQ-031 rst pulsed while state TWO and a read in flight -> out_valid 0 same cycle, stale byte never appears after release.
REQ-032 With FIFO_DRAIN_COUNT_EN, preload byte_count path with 65 537 pops -> byte_count=1 after wrap; without macro, build compiles without port.
